// File: rtl/control_unit.sv
// Control-unit (responder) end of a bus-and-tag channel. It answers selection at ADDRESS,
// accepts a command and moves bytes between the channel and two device-side streams.
// Optional build macro: CONTROL_UNIT_SHORT_BUSY_EN (short busy sequence at selection).
module control_unit #(
    parameter logic [7:0] ADDRESS = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] b_bus_out,
    output logic [7:0] b_bus_in,
    input  logic       b_operational_out,
    output logic       b_request_in,
    input  logic       b_hold_out,
    input  logic       b_select_out,
    input  logic       b_address_out,
    input  logic       b_command_out,
    input  logic       b_service_out,
    input  logic       b_suppress_out,
    output logic       b_select_in,
    output logic       b_operational_in,
    output logic       b_address_in,
    output logic       b_status_in,
    output logic       b_service_in,
    output logic       a_select_out,
    input  logic       a_select_in,
    input  logic       dev_busy,
    input  logic       dev_end,
    output logic [7:0] cmd_tdata,
    output logic       cmd_tvalid,
    input  logic [7:0] rd_tdata,
    input  logic       rd_tvalid,
    output logic       rd_tready,
    output logic [7:0] wr_tdata,
    output logic       wr_tvalid,
    input  logic       wr_tready
);

`ifdef CONTROL_UNIT_SHORT_BUSY_EN
    localparam bit SHORT_BUSY = 1'b1;
`else
    localparam bit SHORT_BUSY = 1'b0;
`endif

    localparam logic [7:0] CMD_WRITE   = 8'h01;
    localparam logic [7:0] CMD_READ    = 8'h02;
    localparam logic [7:0] CMD_NOP     = 8'h03;
    localparam logic [7:0] ST_BUSY     = 8'h10;
    localparam logic [7:0] ST_CE_DE    = 8'h0C;
    localparam logic [7:0] ST_CE_DE_UC = 8'h0E;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PASS,
        S_SEL_ADDR,
        S_CMD,
        S_INIT_STATUS,
        S_DATA,
        S_END_STATUS,
        S_DISCONNECT,
        S_SHORT_BUSY
    } state_t;

    state_t     state_q;
    logic       addr_match_q;
    logic       busy_q;
    logic [7:0] cmd_q;
    logic       cmd_valid_q;
    logic       op_in_q;
    logic       addr_in_q;
    logic       stat_in_q;
    logic       serv_in_q;
    logic [7:0] bus_q;
    logic       rd_ready_q;
    logic [7:0] wr_data_q;
    logic       wr_valid_q;

    logic       addr_match_d;
    logic       is_read;
    logic       is_write;
    logic       tags_out_idle;
    logic [7:0] init_status_d;
    logic       unused_suppress;

    // No command chaining, so suppress-out carries no meaning here.
    assign unused_suppress = b_suppress_out;

    // A select arriving in the same cycle as address-out still sees the fresh compare.
    assign addr_match_d  = b_address_out ? (b_bus_out == ADDRESS) : addr_match_q;
    assign is_read       = (cmd_q == CMD_READ);
    assign is_write      = (cmd_q == CMD_WRITE);
    assign tags_out_idle = !b_service_out && !b_command_out;

    always_comb begin
        init_status_d = ST_CE_DE_UC;
        if (busy_q)
            init_status_d = ST_BUSY;
        else if (is_read || is_write)
            init_status_d = 8'h00;
        else if (cmd_q == CMD_NOP)
            init_status_d = ST_CE_DE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            addr_match_q <= 1'b0;
            busy_q       <= 1'b0;
            cmd_q        <= 8'h00;
            cmd_valid_q  <= 1'b0;
            op_in_q      <= 1'b0;
            addr_in_q    <= 1'b0;
            stat_in_q    <= 1'b0;
            serv_in_q    <= 1'b0;
            bus_q        <= 8'h00;
            rd_ready_q   <= 1'b0;
            wr_data_q    <= 8'h00;
            wr_valid_q   <= 1'b0;
        end else if (!b_operational_out) begin
            // Selective reset from the channel abandons whatever was in progress.
            state_q      <= S_IDLE;
            addr_match_q <= 1'b0;
            busy_q       <= 1'b0;
            cmd_valid_q  <= 1'b0;
            op_in_q      <= 1'b0;
            addr_in_q    <= 1'b0;
            stat_in_q    <= 1'b0;
            serv_in_q    <= 1'b0;
            bus_q        <= 8'h00;
            rd_ready_q   <= 1'b0;
            wr_valid_q   <= 1'b0;
        end else begin
            cmd_valid_q <= 1'b0;
            if (wr_valid_q && wr_tready)
                wr_valid_q <= 1'b0;
            if (state_q != S_IDLE)
                addr_match_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (b_address_out)
                        addr_match_q <= (b_bus_out == ADDRESS);
                    if (b_select_out && b_hold_out && addr_match_d) begin
                        busy_q <= dev_busy;
                        if (SHORT_BUSY && dev_busy) begin
                            stat_in_q <= 1'b1;
                            bus_q     <= ST_BUSY;
                            state_q   <= S_SHORT_BUSY;
                        end else begin
                            op_in_q   <= 1'b1;
                            addr_in_q <= 1'b1;
                            bus_q     <= ADDRESS;
                            state_q   <= S_SEL_ADDR;
                        end
                    end else if (b_select_out && !addr_match_d) begin
                        state_q <= S_PASS;
                    end
                end

                S_PASS: begin
                    if (!b_select_out)
                        state_q <= S_IDLE;
                end

                S_SEL_ADDR: begin
                    if (b_command_out && !b_address_out) begin
                        cmd_q       <= b_bus_out;
                        cmd_valid_q <= 1'b1;
                        state_q     <= S_CMD;
                    end
                end

                S_CMD: begin
                    addr_in_q <= 1'b0;
                    if (!addr_in_q && !b_command_out) begin
                        stat_in_q <= 1'b1;
                        bus_q     <= init_status_d;
                        state_q   <= S_INIT_STATUS;
                    end
                end

                S_INIT_STATUS: begin
                    if (b_service_out) begin
                        stat_in_q <= 1'b0;
                        state_q   <= ((is_read || is_write) && !busy_q) ? S_DATA : S_DISCONNECT;
                    end else if (b_command_out) begin
                        stat_in_q <= 1'b0;
                        state_q   <= S_DISCONNECT;
                    end
                end

                S_DATA: begin
                    if (serv_in_q) begin
                        if (b_service_out) begin
                            serv_in_q <= 1'b0;
                            if (is_write) begin
                                wr_data_q  <= b_bus_out;
                                wr_valid_q <= 1'b1;
                            end
                        end else if (b_command_out) begin
                            // Stop: the byte on offer is dropped.
                            serv_in_q <= 1'b0;
                            state_q   <= S_END_STATUS;
                        end
                    end else if (rd_ready_q) begin
                        if (rd_tvalid) begin
                            rd_ready_q <= 1'b0;
                            bus_q      <= rd_tdata;
                            serv_in_q  <= 1'b1;
                        end else if (dev_end) begin
                            rd_ready_q <= 1'b0;
                            state_q    <= S_END_STATUS;
                        end
                    end else if (tags_out_idle && !wr_valid_q) begin
                        if (dev_end) begin
                            state_q <= S_END_STATUS;
                        end else if (is_read) begin
                            rd_ready_q <= 1'b1;
                        end else begin
                            bus_q     <= 8'h00;
                            serv_in_q <= 1'b1;
                        end
                    end
                end

                S_END_STATUS: begin
                    if (!stat_in_q) begin
                        if (tags_out_idle) begin
                            stat_in_q <= 1'b1;
                            bus_q     <= ST_CE_DE;
                        end
                    end else if (b_service_out || b_command_out) begin
                        stat_in_q <= 1'b0;
                        state_q   <= S_DISCONNECT;
                    end
                end

                S_DISCONNECT: begin
                    op_in_q <= 1'b0;
                    if (!b_select_out && tags_out_idle)
                        state_q <= S_IDLE;
                end

                S_SHORT_BUSY: begin
                    if (b_service_out || b_command_out) begin
                        stat_in_q <= 1'b0;
                        state_q   <= S_DISCONNECT;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Outputs are also gated by operational-out so a selective reset clears them at once.
    assign b_operational_in = op_in_q & b_operational_out;
    assign b_address_in     = addr_in_q & b_operational_out;
    assign b_status_in      = stat_in_q & b_operational_out;
    assign b_service_in     = serv_in_q & b_operational_out;
    assign b_bus_in         = (b_address_in || b_status_in || b_service_in) ? bus_q : 8'h00;
    assign b_request_in     = 1'b0;

    assign a_select_out = (state_q == S_PASS) & b_select_out & b_operational_out;
    assign b_select_in  = (state_q == S_PASS) & a_select_in & b_operational_out;

    assign cmd_tdata  = cmd_q;
    assign cmd_tvalid = cmd_valid_q & b_operational_out;
    assign rd_tready  = rd_ready_q & b_operational_out;
    assign wr_tdata   = wr_data_q;
    assign wr_tvalid  = wr_valid_q & b_operational_out;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: the initial block plays the channel and the device streams.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] b_bus_out;
    logic [7:0] b_bus_in;
    logic       b_operational_out;
    logic       b_request_in;
    logic       b_hold_out, b_select_out, b_address_out, b_command_out, b_service_out, b_suppress_out;
    logic       b_select_in, b_operational_in, b_address_in, b_status_in, b_service_in;
    logic       a_select_out, a_select_in;
    logic       dev_busy, dev_end;
    logic [7:0] cmd_tdata;
    logic       cmd_tvalid;
    logic [7:0] rd_tdata;
    logic       rd_tvalid, rd_tready;
    logic [7:0] wr_tdata;
    logic       wr_tvalid, wr_tready;

    int         tests = 0;
    int         fails = 0;
    int         cmd_cnt = 0;
    logic [7:0] cmd_last = 8'h00;
    int         wr_cnt;
    int         wr_bad;
    logic [7:0] wr_last;
    logic       rd_pend;
    logic [7:0] exp_rd;
    int         resid;

    control_unit #(.ADDRESS(8'h1a)) dut (
        .clk(clk), .reset(reset),
        .b_bus_out(b_bus_out), .b_bus_in(b_bus_in),
        .b_operational_out(b_operational_out), .b_request_in(b_request_in),
        .b_hold_out(b_hold_out), .b_select_out(b_select_out), .b_address_out(b_address_out),
        .b_command_out(b_command_out), .b_service_out(b_service_out), .b_suppress_out(b_suppress_out),
        .b_select_in(b_select_in), .b_operational_in(b_operational_in), .b_address_in(b_address_in),
        .b_status_in(b_status_in), .b_service_in(b_service_in),
        .a_select_out(a_select_out), .a_select_in(a_select_in),
        .dev_busy(dev_busy), .dev_end(dev_end),
        .cmd_tdata(cmd_tdata), .cmd_tvalid(cmd_tvalid),
        .rd_tdata(rd_tdata), .rd_tvalid(rd_tvalid), .rd_tready(rd_tready),
        .wr_tdata(wr_tdata), .wr_tvalid(wr_tvalid), .wr_tready(wr_tready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_tvalid) begin
            cmd_cnt  = cmd_cnt + 1;
            cmd_last = cmd_tdata;
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic tag_in(input int k);
        case (k)
            0:       return b_operational_in;
            1:       return b_address_in;
            2:       return b_status_in;
            3:       return b_service_in;
            default: return b_select_in;
        endcase
    endfunction

    task automatic wait_tag(input int k, input logic v, input string tag);
        int n = 0;
        while (tag_in(k) !== v && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(tag, 16'(tag_in(k)), 16'(v));
    endtask

    task automatic select_and_command(input logic [7:0] cmd);
        b_bus_out = 8'h1a; b_address_out = 1'b1; tick();
        b_select_out = 1'b1; b_hold_out = 1'b1; tick();
        wait_tag(1, 1'b1, "addr_in_rise");
        check("addr_bus", 16'(b_bus_in), 16'h001a);
        check("op_in_sel", 16'(b_operational_in), 16'h0001);
        b_address_out = 1'b0; b_bus_out = 8'h00; tick();
        b_bus_out = cmd; b_command_out = 1'b1; tick();
        wait_tag(1, 1'b0, "addr_in_drop");
        b_command_out = 1'b0; b_bus_out = 8'h00; tick();
        check("cmd_last", 16'(cmd_last), 16'(cmd));
    endtask

    task automatic accept_status(input logic [7:0] exp, input logic use_cmd, input string tag);
        wait_tag(2, 1'b1, "stat_in_rise");
        check(tag, 16'(b_bus_in), 16'(exp));
        if (use_cmd) b_command_out = 1'b1;
        else         b_service_out = 1'b1;
        tick();
        wait_tag(2, 1'b0, "stat_in_drop");
        b_service_out = 1'b0; b_command_out = 1'b0; tick();
    endtask

    task automatic end_selection();
        wait_tag(0, 1'b0, "op_in_drop");
        b_select_out = 1'b0; b_hold_out = 1'b0; tick(2);
    endtask

    // Channel offers `count` bytes then answers the next service-in with stop.
    task automatic run_data(input int count, input logic is_read, input int end_after, output int left);
        int guard = 0;
        left = count;
        while (!b_status_in && guard < 400) begin
            if (rd_pend) begin
                rd_tdata = rd_tdata + 8'h01;
                rd_pend  = 1'b0;
            end
            if (rd_tvalid && rd_tready) rd_pend = 1'b1;
            if (wr_tvalid && wr_tready) begin
                wr_cnt++;
                wr_last = wr_tdata;
                if (wr_tdata !== 8'h99) wr_bad++;
                if (wr_cnt == end_after) dev_end = 1'b1;
            end
            if (b_service_in && !b_service_out && !b_command_out) begin
                if (left > 0) begin
                    if (is_read) begin
                        check("rd_byte", 16'(b_bus_in), 16'(exp_rd));
                        exp_rd = exp_rd + 8'h01;
                    end else begin
                        b_bus_out = 8'h99;
                    end
                    b_service_out = 1'b1;
                    left--;
                end else begin
                    b_command_out = 1'b1;
                end
            end else if (!b_service_in) begin
                b_service_out = 1'b0;
                b_command_out = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        check("data_end", 16'(b_status_in), 16'h0001);
    endtask

    initial begin
        reset = 1'b0;
        b_bus_out = 8'h00; b_operational_out = 1'b1;
        b_hold_out = 1'b0; b_select_out = 1'b0; b_address_out = 1'b0;
        b_command_out = 1'b0; b_service_out = 1'b0; b_suppress_out = 1'b0;
        a_select_in = 1'b0; dev_busy = 1'b0; dev_end = 1'b0;
        rd_tdata = 8'hA0; rd_tvalid = 1'b1; wr_tready = 1'b1;
        wr_cnt = 0; wr_bad = 0; wr_last = 8'h00; rd_pend = 1'b0; exp_rd = 8'hA0; resid = 0;
        tick(2);
        check("reset_tags", {6'b0, b_operational_in, b_address_in, b_status_in, b_service_in,
                             b_select_in, a_select_out, cmd_tvalid, wr_tvalid, rd_tready, b_request_in},
              16'h0000);
        check("reset_bus", 16'(b_bus_in), 16'h0000);
        reset = 1'b1; tick(2);

        // Foreign address: select is passed down the chain.
        b_bus_out = 8'h10; b_address_out = 1'b1; tick();
        b_select_out = 1'b1; b_hold_out = 1'b1; tick();
        check("pass_sel_out", 16'(a_select_out), 16'h0001);
        a_select_in = 1'b1; tick();
        check("pass_sel_in", 16'(b_select_in), 16'h0001);
        check("pass_no_op", 16'(b_operational_in), 16'h0000);
        b_address_out = 1'b0; b_select_out = 1'b0; b_hold_out = 1'b0; a_select_in = 1'b0; tick();
        check("pass_release", 16'(a_select_out), 16'h0000);
        tick(2);

        // Busy device answers READ with busy status and disconnects.
        dev_busy = 1'b1;
        select_and_command(8'h02);
        check("busy_cmd_cnt", 16'(cmd_cnt), 16'd1);
        accept_status(8'h10, 1'b0, "busy_status");
        check("busy_no_serv", 16'(b_service_in), 16'h0000);
        end_selection();
        dev_busy = 1'b0;

        // READ: channel takes six bytes, then stops.
        select_and_command(8'h02);
        accept_status(8'h00, 1'b0, "rd_init_status");
        run_data(6, 1'b1, 0, resid);
        check("rd_resid", 16'(resid), 16'd0);
        check("rd_last", 16'(exp_rd), 16'h00A6);
        accept_status(8'h0C, 1'b0, "rd_end_status");
        end_selection();

        // WRITE: channel offers sixteen bytes, device ends after six.
        wr_cnt = 0; wr_bad = 0;
        select_and_command(8'h01);
        accept_status(8'h00, 1'b0, "wr_init_status");
        run_data(16, 1'b0, 6, resid);
        check("wr_beats", 16'(wr_cnt), 16'd6);
        check("wr_bad", 16'(wr_bad), 16'd0);
        check("wr_last", 16'(wr_last), 16'h0099);
        check("wr_chan_count", 16'(resid), 16'd10);
        accept_status(8'h0C, 1'b0, "wr_end_status");
        dev_end = 1'b0;
        end_selection();

        // NOP ends at initial status; an unknown command gets unit check.
        select_and_command(8'h03);
        accept_status(8'h0C, 1'b0, "nop_status");
        check("nop_no_serv", 16'(b_service_in), 16'h0000);
        end_selection();
        select_and_command(8'hFF);
        accept_status(8'h0E, 1'b1, "bad_cmd_status");
        end_selection();
        check("cmd_count", 16'(cmd_cnt), 16'd5);

        // Selective reset in the middle of a READ.
        rd_pend = 1'b0;
        select_and_command(8'h02);
        accept_status(8'h00, 1'b0, "opd_init_status");
        wait_tag(3, 1'b1, "opd_serv_in");
        b_operational_out = 1'b0; b_select_out = 1'b0; b_hold_out = 1'b0; tick();
        check("opd_tags", {11'b0, b_operational_in, b_address_in, b_status_in, b_service_in, rd_tready},
              16'h0000);
        check("opd_bus", 16'(b_bus_in), 16'h0000);
        b_operational_out = 1'b1; tick(2);
        check("opd_idle", 16'(b_operational_in), 16'h0000);
        select_and_command(8'h03);
        accept_status(8'h0C, 1'b0, "opd_nop_status");
        end_selection();
        check("cmd_count_end", 16'(cmd_cnt), 16'd7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
